step_clock_gen: RTL

- Parametrised step/tempo generator; successor to the plain soft/hard-limit counter.
- Divides CLOCK_50 by a programmable period into step ticks and walks a step index 0..last_step.
- Supports loop and one-shot modes, start/stop/pause control, and a saturating pass (bar) counter.
- Drives the sequencer's step index and the per-step trigger pulse.

---
 rtl/step_clock_gen.sv | 110 +++++++++++
 1 files changed

// File: rtl/step_clock_gen.sv
// Step/tempo generator: divides CLOCK_50 by a programmable period into step
// ticks and walks a step index 0..last_step in loop or one-shot mode.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | not sequencing (after reset or stop); counters hold
// S_RUN  | sequencing; divider counts unless pause is high
// S_DONE | one-shot pass finished; sticky until start or reset
module step_clock_gen #(
   parameter int WIDTH     = 32,
   parameter int STEP_BITS = 4
) (
   input  logic                 CLOCK_50,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 pause,
   input  logic                 one_shot,
   input  logic [WIDTH-1:0]     period,
   input  logic [STEP_BITS-1:0] last_step,
   output logic [STEP_BITS-1:0] step,
   output logic                 tick,
   output logic                 wrap,
   output logic                 running,
   output logic                 done,
   output logic [WIDTH-1:0]     bar_count
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t               state, state_n;
   logic [WIDTH-1:0]     divider, divider_n;
   logic [WIDTH-1:0]     bar_n;
   logic [WIDTH-1:0]     limit;
   logic [STEP_BITS-1:0] step_n;
   logic                 tick_n, wrap_n;
   logic                 mode, mode_n;

   // running/done come straight from the state register, so they stay registered
   assign running = (state == S_RUN);
   assign done    = (state == S_DONE);

   // Terminal divider value; a period of 0 behaves like 1
   assign limit = (period == '0) ? '0 : period - WIDTH'(1);

   // State and counter registers
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         divider   <= '0;
         step      <= '0;
         tick      <= 1'b0;
         wrap      <= 1'b0;
         bar_count <= '0;
         mode      <= 1'b0;
      end else begin
         state     <= state_n;
         divider   <= divider_n;
         step      <= step_n;
         tick      <= tick_n;
         wrap      <= wrap_n;
         bar_count <= bar_n;
         mode      <= mode_n;
      end
   end

   // Next-state logic: stop beats start, start beats counting
   always_comb begin
      state_n   = state;
      divider_n = divider;
      step_n    = step;
      tick_n    = 1'b0;
      wrap_n    = 1'b0;
      bar_n     = bar_count;
      mode_n    = mode;

      if (stop) begin
         // done stays sticky across stop; only start or reset clears it
         state_n   = (state == S_DONE) ? S_DONE : S_IDLE;
         divider_n = '0;
      end else if (start) begin
         state_n   = S_RUN;
         divider_n = '0;
         step_n    = '0;
         bar_n     = '0;
         tick_n    = 1'b1;
         mode_n    = one_shot;
      end else if (state == S_RUN && !pause) begin
         // >= so a period or last_step lowered mid-run cannot overrun
         if (divider >= limit) begin
            divider_n = '0;
            if (step < last_step) begin
               step_n = step + STEP_BITS'(1);
               tick_n = 1'b1;
            end else if (!mode) begin
               step_n = '0;
               tick_n = 1'b1;
               wrap_n = 1'b1;
               if (bar_count != '1)
                  bar_n = bar_count + WIDTH'(1);
            end else begin
               state_n = S_DONE;
            end
         end else begin
            divider_n = divider + WIDTH'(1);
         end
      end
   end

endmodule
